// File: rtl/e_mdu_pkg.sv
// Shared MDU op codes and op-class helpers for the multiply/divide unit.
`timescale 1ns/1ps
package e_mdu_pkg;

    typedef logic [3:0] mdu_op_t;

    localparam mdu_op_t MDU_NOP   = 4'd0;
    localparam mdu_op_t MDU_MULT  = 4'd1;
    localparam mdu_op_t MDU_MULTU = 4'd2;
    localparam mdu_op_t MDU_DIV   = 4'd3;
    localparam mdu_op_t MDU_DIVU  = 4'd4;
    localparam mdu_op_t MDU_MTHI  = 4'd5;
    localparam mdu_op_t MDU_MTLO  = 4'd6;
    localparam mdu_op_t MDU_MFHI  = 4'd7;
    localparam mdu_op_t MDU_MFLO  = 4'd8;

    function automatic logic op_is_mul(input mdu_op_t op);
        return (op == MDU_MULT) || (op == MDU_MULTU);
    endfunction

    function automatic logic op_is_div(input mdu_op_t op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/e_mdu.sv
// Multiply/divide unit with HI/LO: result is computed at launch into pending
// registers; the counter only models latency before commit.
`timescale 1ns/1ps
module e_mdu
    import e_mdu_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Start,
    input  logic [3:0]       MDUOp,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic [WIDTH-1:0] Result,
    output logic [1:0]       dbg_state
);

    // Handshake: Start is a one-cycle strobe accepted only while Busy=0;
    // Start while Busy=1 is dropped. Stall term Start|Busy lives upstream.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2
    } state_e;

    state_e           state, state_nx;
    logic [3:0]       cnt, cnt_nx;
    logic             capture, commit, wr_hi, wr_lo;
    logic [WIDTH-1:0] pend_hi, pend_lo;
    logic             pend_wr;

    logic [WIDTH-1:0]   calc_hi, calc_lo;
    logic               calc_wr;
    logic [2*WIDTH-1:0] prod_s, prod_u;
    logic [WIDTH-1:0]   a_mag, b_mag, b_sdiv, b_udiv;
    logic [WIDTH-1:0]   sq_mag, sr_mag, s_quo, s_rem, u_quo, u_rem;
    logic               b_nz;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        capture  = 1'b0;
        commit   = 1'b0;
        wr_hi    = 1'b0;
        wr_lo    = 1'b0;
        case (state)
            S_IDLE: begin
                if (Start) begin
                    if (op_is_mul(MDUOp)) begin
                        state_nx = S_MUL;
                        cnt_nx   = 4'(MULT_CYCLES);
                        capture  = 1'b1;
                    end else if (op_is_div(MDUOp)) begin
                        state_nx = S_DIV;
                        cnt_nx   = 4'(DIV_CYCLES);
                        capture  = 1'b1;
                    end else begin
                        wr_hi = (MDUOp == MDU_MTHI);
                        wr_lo = (MDUOp == MDU_MTLO);
                    end
                end
            end
            S_MUL, S_DIV: begin
                if (cnt == 4'd1) begin
                    state_nx = S_IDLE;
                    cnt_nx   = 4'd0;
                    commit   = 1'b1;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            default: begin
                state_nx = S_IDLE;
                cnt_nx   = 4'd0;
            end
        endcase
    end

    // Signed divide via magnitudes; a zero divisor is swapped for 1 so the
    // divider never sees zero, and the write is suppressed instead.
    always_comb begin
        prod_s = {{WIDTH{A[WIDTH-1]}}, A} * {{WIDTH{B[WIDTH-1]}}, B};
        prod_u = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};
        b_nz   = |B;
        a_mag  = A[WIDTH-1] ? ('0 - A) : A;
        b_mag  = B[WIDTH-1] ? ('0 - B) : B;
        b_sdiv = b_nz ? b_mag : {{(WIDTH-1){1'b0}}, 1'b1};
        b_udiv = b_nz ? B : {{(WIDTH-1){1'b0}}, 1'b1};
        sq_mag = a_mag / b_sdiv;
        sr_mag = a_mag % b_sdiv;
        s_quo  = (A[WIDTH-1] ^ B[WIDTH-1]) ? ('0 - sq_mag) : sq_mag;
        s_rem  = A[WIDTH-1] ? ('0 - sr_mag) : sr_mag;
        u_quo  = A / b_udiv;
        u_rem  = A % b_udiv;

        calc_hi = '0;
        calc_lo = '0;
        calc_wr = 1'b0;
        case (MDUOp)
            MDU_MULT:  begin {calc_hi, calc_lo} = prod_s; calc_wr = 1'b1; end
            MDU_MULTU: begin {calc_hi, calc_lo} = prod_u; calc_wr = 1'b1; end
            MDU_DIV:   begin calc_hi = s_rem; calc_lo = s_quo; calc_wr = b_nz; end
            MDU_DIVU:  begin calc_hi = u_rem; calc_lo = u_quo; calc_wr = b_nz; end
            default:   ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            HI      <= '0;
            LO      <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
            pend_wr <= 1'b0;
        end else begin
            if (capture) begin
                pend_hi <= calc_hi;
                pend_lo <= calc_lo;
                pend_wr <= calc_wr;
            end
            if (commit && pend_wr) begin
                HI <= pend_hi;
                LO <= pend_lo;
            end
            if (wr_hi) HI <= A;
            if (wr_lo) LO <= A;
        end
    end

    always_comb begin
        Result = '0;
        if (MDUOp == MDU_MFHI)      Result = HI;
        else if (MDUOp == MDU_MFLO) Result = LO;
    end

    assign Busy      = (state != S_IDLE);
    assign dbg_state = state;

endmodule
